// File: rtl/approx_booth_mult_seq_if.sv
`default_nettype none
// ============================================================================
// approx_booth_mult_seq_if : operand / product handshake bundle.
// err_o exists only when ABM_ERR_MON_EN is defined.   Rev 1.0
// ============================================================================
interface approx_booth_mult_seq_if #(
  parameter int WIDTH = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       a_i;
  logic [WIDTH-1:0]       b_i;
  logic                   mode_i;
  logic                   flush_i;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     product_o;
`ifdef ABM_ERR_MON_EN
  logic signed [2*WIDTH:0] err_o;
`endif

  modport master (
    output in_valid, a_i, b_i, mode_i, flush_i, out_ready,
    input  in_ready, out_valid, product_o
`ifdef ABM_ERR_MON_EN
    , input err_o
`endif
  );

  modport slave (
    input  in_valid, a_i, b_i, mode_i, flush_i, out_ready,
    output in_ready, out_valid, product_o
`ifdef ABM_ERR_MON_EN
    , output err_o
`endif
  );
endinterface
`default_nettype wire

// File: rtl/approx_booth_mult_seq.sv
`default_nettype none
// ============================================================================
// approx_booth_mult_seq : sequential radix-4 Booth multiplier, exact or PPG-2S
// approximate partial products; ABM_ERR_MON_EN adds error monitor.  Rev 1.0
// ============================================================================
module approx_booth_mult_seq #(
  parameter int WIDTH         = 16,
  parameter int APPROX_DIGITS = WIDTH / 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  approx_booth_mult_seq_if.slave  bus
);
  localparam int DIGITS = WIDTH / 2;
  localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW     = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             mode_q, mode_d;
  logic [PW-1:0]    acc_q, acc_d;

  logic [WIDTH:0]   b_ext;
  logic [2:0]       triple;
  logic             neg, zero, two, use_approx;
  logic [WIDTH+1:0] a_x, mag, pp_ex;
  logic [WIDTH-1:0] p_ax;
  logic [PW-1:0]    pp_ex_ext, pp_sel, pp_shift;

  assign b_ext  = {b_q, 1'b0};
  assign triple = b_ext[2*cnt_q +: 3];
  assign neg    = triple[2] & ~(triple[1] & triple[0]);
  assign zero   = (triple == 3'b000) | (triple == 3'b111);
  assign two    = (triple == 3'b011) | (triple == 3'b100);

  // Exact digit product d*A at WIDTH+2 bits
  assign a_x       = {{2{a_q[WIDTH-1]}}, a_q};
  assign mag       = zero ? '0 : (two ? {a_x[WIDTH:0], 1'b0} : a_x);
  assign pp_ex     = neg ? (~mag + 1'b1) : mag;
  assign pp_ex_ext = {{(PW-WIDTH-2){pp_ex[WIDTH+1]}}, pp_ex};

  // PPG-2S: magnitude 2 ignored, negation carry folded into bit 0 via the digit MSB
  always_comb begin
    p_ax    = neg ? ~a_q : (zero ? '0 : a_q);
    p_ax[0] = p_ax[0] | triple[2];
  end

  assign use_approx = mode_q && (int'(cnt_q) < APPROX_DIGITS);
  assign pp_sel     = use_approx ? {{(PW-WIDTH){p_ax[WIDTH-1]}}, p_ax} : pp_ex_ext;
  assign pp_shift   = pp_sel << (2*cnt_q);

`ifdef ABM_ERR_MON_EN
  logic [PW-1:0] acc_ex_q, acc_ex_d, pp_ex_shift;
  assign pp_ex_shift = pp_ex_ext << (2*cnt_q);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
`ifdef ABM_ERR_MON_EN
    acc_ex_d = acc_ex_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a_i;
          b_d     = bus.b_i;
          mode_d  = bus.mode_i;
          acc_d   = '0;
          cnt_d   = '0;
`ifdef ABM_ERR_MON_EN
          acc_ex_d = '0;
`endif
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        acc_d = acc_q + pp_shift;
`ifdef ABM_ERR_MON_EN
        acc_ex_d = acc_ex_q + pp_ex_shift;
`endif
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort outranks both accept and output handshake
    if (bus.flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      acc_d   = '0;
`ifdef ABM_ERR_MON_EN
      acc_ex_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      acc_q   <= '0;
`ifdef ABM_ERR_MON_EN
      acc_ex_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
`ifdef ABM_ERR_MON_EN
      acc_ex_q <= acc_ex_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.product_o = acc_q;
`ifdef ABM_ERR_MON_EN
  assign bus.err_o = (state_q == S_DONE)
                   ? ($signed({acc_ex_q[PW-1], acc_ex_q}) - $signed({acc_q[PW-1], acc_q}))
                   : '0;
`endif
endmodule
`default_nettype wire

// File: doc/approx_booth_mult_seq.md
Name: approx_booth_mult_seq

Overview:
- Sequential, parametrised radix-4 Booth multiplier with run-time selection of exact or approximate partial-product generation.
- Approximate mode uses the two-signal PPG (PPG-2S): the two-flag is ignored and the negation +1 is folded into bit 0 by OR with the digit MSB.
- Processes one Booth digit per cycle into a 2N-bit accumulator, so one instance replaces the wide combinational array.
- Sits behind a valid/ready handshake in the datapath for accuracy/area trade-off studies.

Parameters:
WIDTH, 16, operand width N; even, >= 4.
APPROX_DIGITS, WIDTH/2, in approx mode digits 0..APPROX_DIGITS-1 use PPG-2S; higher digits exact; range 0..WIDTH/2.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operands valid.
in_ready  out  1  block can accept operands.
a_i  in  WIDTH  signed multiplicand A.
b_i  in  WIDTH  signed multiplier B (Booth-recoded).
mode_i  in  1  0 = exact, 1 = approximate; sampled at accept.
flush_i  in  1  synchronous abort.
out_valid  out  1  product valid.
out_ready  in  1  consumer accepts product.
product_o  out  2*WIDTH  signed product.

Behaviour:
- Reset state: IDLE. in_ready=1, out_valid=0, product_o=0, accumulator=0, digit counter=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready: latch A, B, mode; clear acc; cnt=0; go to BUSY.
  - BUSY: in_ready=0. Each cycle: add PP(cnt) << 2*cnt to acc; cnt++. After the cycle with cnt=WIDTH/2-1, go to DONE.
  - DONE: out_valid=1; product_o=acc, held stable. On out_ready, go to IDLE.
- Timing:
  - out_valid rises exactly WIDTH/2 cycles after the accept edge (8 for N=16).
  - in_ready is low in BUSY and DONE; it returns the cycle after the out handshake.
  - Period per op without backpressure is WIDTH/2+2 cycles.
- Digit i triple: {B[2i+1], B[2i], B[2i-1]}, with B[-1]=0. Encoding:
  - 000, 111 -> zero
  - 001, 010 -> +1
  - 011 -> +2
  - 100 -> -2 (neg, two)
  - 101, 110 -> -1 (neg)
- Exact PP: d_i*A, with d_i in {-2..2}, computed at N+2 bits, sign-extended.
- Approx PP (PPG-2S), N bits:
  - P = neg ? ~A : (zero ? 0 : A).
  - P[0] is then replaced by P[0] | B[2i+1].
  - P is sign-extended from bit N-1.
- Accumulation is modulo 2^(2N) (truncate; no saturation).
- Boundary conditions:
  - flush_i in any state: next state IDLE, out_valid=0, acc and cnt cleared. flush_i has priority over accept and over the output handshake.
  - in_valid during BUSY/DONE: ignored, not consumed.
  - rst_n low mid-operation: immediate return to reset state; operation lost.
  - Operand changes after accept: no effect.
  - APPROX_DIGITS=0: approx mode is identical to exact mode.

Optional Feature:
- Macro: ABM_ERR_MON_EN.
- When defined:
  - Adds output err_o (2*WIDTH+1, signed).
  - A second accumulator always sums exact PPs in parallel.
  - In DONE, err_o = exact_product - product_o (product_o sign-extended); it is 0 in exact mode.
  - err_o resets to 0 and is cleared by flush_i.
- When undefined: err_o port and second accumulator absent; all other behaviour unchanged.

Test Plan:
1. WIDTH=16, mode=0, A=5, B=3 -> product_o=15; out_valid 8 cycles after accept.
2. Mode=1, A=5, B=3 -> product_o=15; with ABM_ERR_MON_EN, err_o=0.
3. Mode=1, A=5, B=2 -> product_o=15 (exact 10); err_o=-5. Same operands with mode=0 -> 10.
4. Mode=1, A=4, B=16'hFFFF -> product_o=32'h0000554F (21839); mode=0 -> 32'hFFFFFFFC (-4).
5. Hold out_ready=0 for 5 cycles in DONE -> product_o stable, in_ready=0, new in_valid not consumed. Then out_ready=1 -> IDLE the next cycle.
6. Assert flush_i at BUSY cycle 3, and separately assert rst_n low in BUSY -> IDLE, out_valid=0, in_ready=1. The next op, mode=0, A=-32768, B=-32768 -> 32'h40000000.
